// File: rtl/search_pkg.sv
// Shared definitions for the ping-pong search-window buffer: depth, bank states
// and the wrap-around read address helper.
package search_pkg;

    localparam int DEPTH  = 24;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        READING = 2'd2
    } bank_st_e;

    // Operands are both below depth, so a single conditional subtract is enough.
    function automatic logic [ADDR_W-1:0] mod_add(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W:0]   depth
    );
        logic [ADDR_W:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s >= depth) begin
            sum_s = sum_s - depth;
        end else begin
            sum_s = sum_s;
        end
        return sum_s[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/search_mem_bank.sv
// One DEPTH-word pixel bank: synchronous write port and a registered read port
// whose output register clears on reset.
module search_mem_bank
    import search_pkg::*;
#(
    parameter int WORD_WIDETH = 8,
    parameter int BANK_DEPTH  = DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [WORD_WIDETH-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [WORD_WIDETH-1:0] rdata_o
);

    logic [WORD_WIDETH-1:0] mem_r [BANK_DEPTH];
    logic [WORD_WIDETH-1:0] rdata_q;

    // Storage array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {WORD_WIDETH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_r[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/search_mem.sv
// Ping-pong search-window buffer: fills one bank from the pixel stream while the
// other is replayed to the PE array starting at a ctr_word displacement.
module search_mem
    import search_pkg::*;
#(
    parameter int WORD_WIDETH = 8,
    parameter int OFS_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WORD_WIDETH-1:0] in_data,
    output logic                   in_ready,
    input  logic [OFS_W-1:0]       ctr_word,
    input  logic                   mem_en_input,
    input  logic                   mem_init_mode,
    output logic                   out_valid,
    output logic [WORD_WIDETH-1:0] out_data,
    output logic                   out_last,
    output logic                   rd_bank,
    output logic                   underrun
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              pass_act_q, pass_act_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] ofs_q, ofs_d;
    logic              underrun_q, underrun_d;
    logic              out_valid_q, out_last_q, out_sel_q;

    logic              in_ready_s;
    logic              rd_readable_s;
    logic              issue_s, last_s;
    logic [ADDR_W-1:0] rd_addr_s, cnt_next_s, ctr_ext_s;
    logic [1:0]        we_s, re_s;
    logic [WORD_WIDETH-1:0] rdata_s [2];

    assign in_ready_s    = (bank_st_q[wr_bank_q] == EMPTY);
    assign rd_readable_s = (bank_st_q[rd_bank_q] == FULL) || (bank_st_q[rd_bank_q] == READING);
    assign cnt_next_s    = rd_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign ctr_ext_s     = {{(ADDR_W-OFS_W){1'b0}}, ctr_word};

    // Write-side fill control and read-side pass control.
    always_comb begin
        bank_st_d[0] = bank_st_q[0];
        bank_st_d[1] = bank_st_q[1];
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        rd_bank_d    = rd_bank_q;
        pass_act_d   = pass_act_q;
        rd_cnt_d     = rd_cnt_q;
        ofs_d        = ofs_q;
        underrun_d   = underrun_q;
        we_s         = 2'b00;
        re_s         = 2'b00;
        issue_s      = 1'b0;
        last_s       = 1'b0;
        rd_addr_s    = {ADDR_W{1'b0}};

        if (in_valid && in_ready_s) begin
            we_s[wr_bank_q] = 1'b1;
            if (wr_ptr_q == LAST_IDX) begin
                bank_st_d[wr_bank_q] = FULL;
                wr_ptr_d             = {ADDR_W{1'b0}};
                wr_bank_d            = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // Start and restart both rewind to word 0 of the pass at a fresh offset.
        if (mem_en_input) begin
            if (mem_init_mode) begin
                if (rd_readable_s) begin
                    issue_s              = 1'b1;
                    ofs_d                = ctr_ext_s;
                    rd_cnt_d             = {ADDR_W{1'b0}};
                    pass_act_d           = 1'b1;
                    bank_st_d[rd_bank_q] = READING;
                    rd_addr_s            = mod_add({ADDR_W{1'b0}}, ctr_ext_s, DEPTH_W);
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                if (pass_act_q) begin
                    issue_s   = 1'b1;
                    rd_cnt_d  = cnt_next_s;
                    rd_addr_s = mod_add(cnt_next_s, ofs_q, DEPTH_W);
                    if (cnt_next_s == LAST_IDX) begin
                        last_s               = 1'b1;
                        pass_act_d           = 1'b0;
                        bank_st_d[rd_bank_q] = EMPTY;
                        rd_bank_d            = ~rd_bank_q;
                    end else begin
                        last_s = 1'b0;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
        end else begin
            issue_s = 1'b0;
        end

        re_s[rd_bank_q] = issue_s;
    end

    // Control state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= {ADDR_W{1'b0}};
            rd_bank_q    <= 1'b0;
            pass_act_q   <= 1'b0;
            rd_cnt_q     <= {ADDR_W{1'b0}};
            ofs_q        <= {ADDR_W{1'b0}};
            underrun_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_sel_q    <= 1'b0;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_bank_q    <= rd_bank_d;
            pass_act_q   <= pass_act_d;
            rd_cnt_q     <= rd_cnt_d;
            ofs_q        <= ofs_d;
            underrun_q   <= underrun_d;
            out_valid_q  <= issue_s;
            out_last_q   <= issue_s && last_s;
            out_sel_q    <= issue_s ? rd_bank_q : out_sel_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        search_mem_bank #(
            .WORD_WIDETH (WORD_WIDETH),
            .BANK_DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we_s[b]),
            .waddr_i (wr_ptr_q),
            .wdata_i (in_data),
            .re_i    (re_s[b]),
            .raddr_i (rd_addr_s),
            .rdata_o (rdata_s[b])
        );
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_sel_q ? rdata_s[1] : rdata_s[0];
    assign out_last  = out_last_q;
    assign rd_bank   = rd_bank_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_search_mem.sv
// Self-checking bench for search_mem: vector table for the basic offset pass,
// scripted sequences for back-pressure, pauses, restarts, underrun and reset.
module tb_search_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic [3:0] ctr_word = 4'd0;
    logic       mem_en_input = 1'b0;
    logic       mem_init_mode = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       rd_bank;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       en;
        logic       init;
        logic [3:0] cw;
        logic       ev;
        logic [7:0] ed;
        logic       el;
    } vec_t;
    vec_t tbl[24];

    search_mem #(.WORD_WIDETH(8), .OFS_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ctr_word      (ctr_word),
        .mem_en_input  (mem_en_input),
        .mem_init_mode (mem_init_mode),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .rd_bank       (rd_bank),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, push expectation, step the edge, pop and compare.
    task automatic cyc(input logic en, input logic init, input logic [3:0] cw,
                       input logic iv, input logic [7:0] id,
                       input logic ev, input logic [7:0] ed, input logic el);
        exp_t e;
        mem_en_input  = en;
        mem_init_mode = init;
        ctr_word      = cw;
        in_valid      = iv;
        in_data       = id;
        sb_q.push_back('{ev, ed, el});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("out_valid", int'(out_valid), int'(e.v));
        chk("out_last", int'(out_last), int'(e.v && e.l));
        if (e.v) begin
            chk("out_data", int'(out_data), int'(e.d));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic push(input logic [7:0] d);
        chk("in_ready_push", int'(in_ready), 1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, d, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_rd_bank"}, int'(rd_bank), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
    endtask

    task automatic do_reset();
        mem_en_input = 1'b0;
        mem_init_mode = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_table();
        for (int k = 0; k < 24; k++) begin
            cyc(tbl[k].en, tbl[k].init, tbl[k].cw, 1'b0, 8'd0, tbl[k].ev, tbl[k].ed, tbl[k].el);
        end
        chk("tbl_rd_bank", int'(rd_bank), 1);
        chk("tbl_underrun", int'(underrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 24; k++) begin
            tbl[k] = '{1'b1, (k == 0), 4'd5, 1'b1, 8'((k + 5) % 24), (k == 23)};
        end

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("init");
        rst_n = 1'b1;

        // Basic offset pass on bank 0.
        for (int k = 0; k < 24; k++) push(8'(k));
        chk("ready_after_fill0", int'(in_ready), 1);
        run_table();

        // Back-pressure: fill bank 1 then bank 0 without reading.
        for (int k = 0; k < 24; k++) push(8'(100 + k));
        for (int k = 0; k < 24; k++) push(8'(150 + k));
        chk("ready_full", int'(in_ready), 0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 8'hEE, 1'b0, 8'd0, 1'b0);
        chk("ready_49th", int'(in_ready), 0);
        for (int k = 0; k < 24; k++) begin
            cyc(1'b1, (k == 0), 4'd0, 1'b0, 8'd0, 1'b1, 8'(100 + k), (k == 23));
            if (k < 23) chk("ready_held", int'(in_ready), 0);
        end
        chk("ready_released", int'(in_ready), 1);
        chk("rd_bank_b0", int'(rd_bank), 0);

        // Paused pass on bank 0 with alternating enable; the rejected pixel must not appear.
        for (int k = 0; k < 24; k++) begin
            cyc(1'b1, (k == 0), 4'd3, 1'b0, 8'd0, 1'b1, 8'(150 + (k + 3) % 24), (k == 23));
            idle();
        end
        chk("pause_rd_bank", int'(rd_bank), 1);
        chk("pause_underrun", int'(underrun), 0);

        // Underrun: init with no FULL bank, sticky until reset.
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("ur_init", int'(underrun), 1);
        idle();
        idle();
        chk("ur_sticky", int'(underrun), 1);
        do_reset();
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("ur_advance", int'(underrun), 1);
        do_reset();

        // Init on the same edge as the completing write is an underrun; next cycle works.
        for (int k = 0; k < 23; k++) push(8'(200 + k));
        cyc(1'b1, 1'b1, 4'd7, 1'b1, 8'(223), 1'b0, 8'd0, 1'b0);
        chk("ur_same_edge", int'(underrun), 1);
        for (int k = 0; k <= 10; k++) begin
            cyc(1'b1, (k == 0), 4'd7, 1'b0, 8'd0, 1'b1, 8'(200 + (k + 7) % 24), 1'b0);
        end
        // Restart at rd_cnt=10 with offset 0.
        for (int k = 0; k < 24; k++) begin
            cyc(1'b1, (k == 0), 4'd0, 1'b0, 8'd0, 1'b1, 8'(200 + k), (k == 23));
        end
        chk("restart_rd_bank", int'(rd_bank), 1);
        idle();

        // Async reset at rd_cnt=12 while bank 0 is filling.
        for (int k = 0; k < 24; k++) push(8'(30 + k));
        for (int k = 0; k <= 12; k++) begin
            cyc(1'b1, (k == 0), 4'd2, 1'b1, 8'(60 + k), 1'b1, 8'(30 + (k + 2) % 24), 1'b0);
        end
        chk("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async");
        mem_en_input = 1'b0;
        mem_init_mode = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) push(8'(k));
        run_table();

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
